// File: rtl/proc_0_nios2_gen2_0_cpu_mult_combine.sv
// Combines the three 16x16 partial products of a 32x32 multiply into the low product word,
// carried through enable-gated A and W stages, with flush and a saturating retire counter.
module proc_0_nios2_gen2_0_cpu_mult_combine #(
  parameter int DST_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             M_en,
  input  logic             M_mul_valid,
  input  logic [DST_W-1:0] M_dst_regnum,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
  input  logic             pipe_flush,
  input  logic             cnt_clr,
  output logic             W_mul_valid,
  output logic [31:0]      W_mul_result,
  output logic [DST_W-1:0] W_dst_regnum,
  output logic [CNT_W-1:0] mul_retired
);

  logic [31:0]      a_p1;
  logic [15:0]      a_cross;
  logic [DST_W-1:0] a_dst;
  logic             a_valid;
  logic             retire;

  // Upper halves of the cross products only contribute above bit 31.
  logic unused_hi;
  assign unused_hi = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

  assign retire = W_mul_valid & M_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_p1         <= '0;
      a_cross      <= '0;
      a_dst        <= '0;
      a_valid      <= 1'b0;
      W_mul_result <= '0;
      W_dst_regnum <= '0;
      W_mul_valid  <= 1'b0;
    end else begin
      if (M_en) begin
        a_p1         <= M_mul_cell_p1;
        a_cross      <= M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
        a_dst        <= M_dst_regnum;
        W_mul_result <= a_p1 + {a_cross, 16'h0000};
        W_dst_regnum <= a_dst;
      end
      // Flush kills valids even during a stall; data registers are left alone.
      if (pipe_flush) begin
        a_valid     <= 1'b0;
        W_mul_valid <= 1'b0;
      end else if (M_en) begin
        a_valid     <= M_mul_valid;
        W_mul_valid <= a_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_retired <= '0;
    end else if (cnt_clr) begin
      mul_retired <= '0;
    end else if (retire && (mul_retired != {CNT_W{1'b1}})) begin
      mul_retired <= mul_retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_0_nios2_gen2_0_cpu_mult_combine.sv
// Bench for the multiply combine stage: table vectors plus directed stall/flush/counter/reset
// sequences, with expected products queued at issue and checked when they retire from W.
module tb_proc_0_nios2_gen2_0_cpu_mult_combine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        M_en = 1'b0;
  logic        M_mul_valid = 1'b0;
  logic [4:0]  M_dst_regnum = '0;
  logic [31:0] M_mul_cell_p1 = '0;
  logic [31:0] M_mul_cell_p2 = '0;
  logic [31:0] M_mul_cell_p3 = '0;
  logic        pipe_flush = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        W_mul_valid;
  logic [31:0] W_mul_result;
  logic [4:0]  W_dst_regnum;
  logic [15:0] mul_retired;
  logic        s_valid;
  logic [31:0] s_result;
  logic [4:0]  s_dst;
  logic [2:0]  s_retired;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] res;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  dst;
    logic        v;
    logic [31:0] exp;
  } vec_t;

  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  proc_0_nios2_gen2_0_cpu_mult_combine dut (
    .clk(clk), .reset_n(reset_n), .M_en(M_en), .M_mul_valid(M_mul_valid),
    .M_dst_regnum(M_dst_regnum), .M_mul_cell_p1(M_mul_cell_p1),
    .M_mul_cell_p2(M_mul_cell_p2), .M_mul_cell_p3(M_mul_cell_p3),
    .pipe_flush(pipe_flush), .cnt_clr(cnt_clr), .W_mul_valid(W_mul_valid),
    .W_mul_result(W_mul_result), .W_dst_regnum(W_dst_regnum), .mul_retired(mul_retired)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  proc_0_nios2_gen2_0_cpu_mult_combine #(.DST_W(5), .CNT_W(3)) u_sat (
    .clk(clk), .reset_n(reset_n), .M_en(M_en), .M_mul_valid(M_mul_valid),
    .M_dst_regnum(M_dst_regnum), .M_mul_cell_p1(M_mul_cell_p1),
    .M_mul_cell_p2(M_mul_cell_p2), .M_mul_cell_p3(M_mul_cell_p3),
    .pipe_flush(pipe_flush), .cnt_clr(cnt_clr), .W_mul_valid(s_valid),
    .W_mul_result(s_result), .W_dst_regnum(s_dst), .mul_retired(s_retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic v, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [4:0] dst, input logic fl,
                       input logic clr, input logic [31:0] expv);
    M_en          = en;
    M_mul_valid   = v;
    M_dst_regnum  = dst;
    M_mul_cell_p1 = {16'h0, s1[15:0]} * {16'h0, s2[15:0]};
    M_mul_cell_p2 = {16'h0, s1[15:0]} * {16'h0, s2[31:16]};
    M_mul_cell_p3 = {16'h0, s1[31:16]} * {16'h0, s2[15:0]};
    pipe_flush    = fl;
    cnt_clr       = clr;
    if (en && v && !fl) sb.push_back({dst, expv});
    @(posedge clk);
    #1;
    if (fl) sb.delete();
  endtask

  task automatic bubble(input logic en);
    drive(en, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
  endtask

  // Retire monitor: results are compared against the queue, the counter against a model.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_cnt = '0;
    end else begin
      chk("retired_cnt", {16'h0, mul_retired}, {16'h0, exp_cnt});
      if (W_mul_valid && M_en) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_retire: got result 0x%08h, none expected at %0t",
                   W_mul_result, $time);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("result", W_mul_result, e.res);
          chk("dst", {27'h0, W_dst_regnum}, {27'h0, e.dst});
        end
      end
      if (cnt_clr) exp_cnt = '0;
      else if (W_mul_valid && M_en && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
  end

  initial begin
    vec_t tbl[8];
    tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'h0000_0001};
    tbl[1] = '{32'h0001_0001, 32'h0001_0001, 5'd7, 1'b1, 32'h0002_0001};
    tbl[2] = '{32'h0001_0000, 32'h0001_0000, 5'd9, 1'b1, 32'h0000_0000};
    tbl[3] = '{32'h0000_0003, 32'h0000_0005, 5'd1, 1'b1, 32'h0000_000F};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0, 32'h0000_0000};
    tbl[5] = '{32'h0000_FFFF, 32'h0000_FFFF, 5'd2, 1'b1, 32'hFFFE_0001};
    tbl[6] = '{32'h0001_0000, 32'h0000_FFFF, 5'd4, 1'b1, 32'hFFFF_0000};
    tbl[7] = '{32'h8000_0000, 32'h0000_0003, 5'd5, 1'b1, 32'h8000_0000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, W_mul_valid}, 32'h0);
    chk("rst_result", W_mul_result, 32'h0);
    chk("rst_dst", {27'h0, W_dst_regnum}, 32'h0);
    chk("rst_cnt", {16'h0, mul_retired}, 32'h0);
    reset_n = 1'b1;
    bubble(1'b1);

    // Latency: first vector visible in W exactly two enabled edges after issue.
    drive(1'b1, tbl[0].v, tbl[0].s1, tbl[0].s2, tbl[0].dst, 1'b0, 1'b0, tbl[0].exp);
    chk("lat_a_not_w", {31'h0, W_mul_valid}, 32'h0);
    for (int i = 1; i < 8; i++)
      drive(1'b1, tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].dst, 1'b0, 1'b0, tbl[i].exp);
    repeat (2) bubble(1'b1);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      drive(1'b1, 1'b1, a, b, 5'(i), 1'b0, 1'b0, a * b);
    end
    repeat (2) bubble(1'b1);

    // Back-to-back then stall: W must hold the second result.
    drive(1'b1, 1'b1, 32'd3, 32'd5, 5'd11, 1'b0, 1'b0, 32'h0000_000F);
    drive(1'b1, 1'b1, 32'h0001_0001, 32'h0001_0001, 5'd12, 1'b0, 1'b0, 32'h0002_0001);
    chk("b2b_first", W_mul_result, 32'h0000_000F);
    bubble(1'b1);
    chk("b2b_second", W_mul_result, 32'h0002_0001);
    for (int i = 0; i < 3; i++) begin
      bubble(1'b0);
      chk("stall_hold_res", W_mul_result, 32'h0002_0001);
      chk("stall_hold_vld", {31'h0, W_mul_valid}, 32'h1);
    end
    repeat (2) bubble(1'b1);

    // Flush while stalled kills the multiply sitting in A.
    drive(1'b1, 1'b1, 32'd6, 32'd7, 5'd13, 1'b0, 1'b0, 32'd42);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 32'd0);
    chk("flush_a_valid", {31'h0, dut.a_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      bubble(1'b1);
      chk("flush_no_w", {31'h0, W_mul_valid}, 32'h0);
    end

    // Flush with enable: capture data but no valid.
    drive(1'b1, 1'b1, 32'd9, 32'd9, 5'd14, 1'b1, 1'b0, 32'd81);
    chk("flush_en_a_valid", {31'h0, dut.a_valid}, 32'h0);
    repeat (2) bubble(1'b1);

    // Saturation on the narrow copy, then clear beating a retire.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 32'd0);
    chk("clr_sat", {29'h0, s_retired}, 32'h0);
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b1, 32'(i + 2), 32'd3, 5'd1, 1'b0, 1'b0, 32'((i + 2) * 3));
    chk("sat_six", {29'h0, s_retired}, 32'd6);
    drive(1'b1, 1'b1, 32'd100, 32'd3, 5'd1, 1'b0, 1'b0, 32'd300);
    repeat (3) bubble(1'b1);
    chk("sat_stop", {29'h0, s_retired}, 32'd7);
    drive(1'b1, 1'b1, 32'd4, 32'd4, 5'd2, 1'b0, 1'b0, 32'd16);
    bubble(1'b1);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 32'd0);
    chk("clr_beats_inc_sat", {29'h0, s_retired}, 32'h0);
    chk("clr_beats_inc", {16'h0, mul_retired}, 32'h0);
    bubble(1'b1);

    // Asynchronous reset with live ops in A and W.
    drive(1'b1, 1'b1, 32'd5, 32'd5, 5'd3, 1'b0, 1'b0, 32'd25);
    drive(1'b1, 1'b1, 32'd6, 32'd6, 5'd4, 1'b0, 1'b0, 32'd36);
    #1;
    reset_n = 1'b0;
    M_mul_valid = 1'b0;
    #1;
    chk("arst_valid", {31'h0, W_mul_valid}, 32'h0);
    chk("arst_result", W_mul_result, 32'h0);
    chk("arst_dst", {27'h0, W_dst_regnum}, 32'h0);
    chk("arst_a_valid", {31'h0, dut.a_valid}, 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bubble(1'b1);
      chk("post_rst_no_w", {31'h0, W_mul_valid}, 32'h0);
    end
    drive(1'b1, 1'b1, 32'h0001_0001, 32'h0001_0001, 5'd7, 1'b0, 1'b0, 32'h0002_0001);
    repeat (3) bubble(1'b1);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
